mp_add_sched: RTL and testbench
===============================

// Module: mp_add_sched
// PURPOSE
//  Multi-precision add/subtract scheduler that shares one 32-bit carry-select adder among NREQ requesters.
//  - Arbitrates round-robin and accepts one WORDS*W-bit operation at a time.
//  - Sequences the operation through the adder one word per cycle, LSW first, carrying between words.
//  - Returns the full-width result with a valid/ready handshake.
//  - Sits between arithmetic clients and the shared adder datapath.
// PARAMETERS
//  W      32  adder word width in bits
//  WORDS  4   words per operation; operand width = W*WORDS (128 by default)
//  NREQ   2   number of requesters, >=2; IDW = $clog2(NREQ)
// PORTS
//  clk        in   1           rising-edge clock
//  rst        in   1           asynchronous, active-high reset
//  req_valid  in   NREQ        requester i presents an operation
//  req_ready  out  NREQ        one-hot grant; handshake when req_valid[i]&req_ready[i]
//  req_sub    in   NREQ        per requester: 1 = a-b, 0 = a+b
//  req_a      in   NREQ*W*WORDS  operand A, requester i at [i*W*WORDS +: W*WORDS]
//  req_b      in   NREQ*W*WORDS  operand B, same packing
//  rsp_valid  out  1           result available
//  rsp_ready  in   1           consumer accepts result
//  rsp_sum    out  W*WORDS     result, modulo 2^(W*WORDS)
//  rsp_cout   out  1           carry out of MSW (for sub: 1 = no borrow)
//  rsp_id     out  IDW         index of the requester that issued the op
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, rr_ptr=0, idx=0, carry=0.
//   - Outputs: req_ready=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  IDLE:
//   - Grant g is the first i with req_valid[i]=1, searching from rr_ptr upward with wrap.
//   - req_ready=onehot(g), driven combinationally; req_ready=0 outside IDLE or when no req_valid.
//   - On handshake: latch A, B, sub, and id=g; carry<=sub; idx<=0; rr_ptr<=(g+1)%NREQ; go to RUN.
//  RUN, one word per cycle:
//   - Adder inputs: a=A[idx], b=sub ? ~B[idx] : B[idx], cin=carry.
//   - Registered per cycle: sum word -> result[idx]; carry<=cout.
//   - idx==WORDS-1: rsp_cout<=cout and go to DONE; otherwise idx<=idx+1.
//  DONE:
//   - rsp_valid=1; rsp_sum, rsp_cout, rsp_id are stable until the handshake.
//   - On rsp_ready: go to IDLE, rsp_valid=0 next cycle.
//   - rsp_ready arriving early or while low has no effect.
//  Latency: handshake in cycle 0; RUN occupies cycles 1..WORDS; rsp_valid first high in cycle WORDS+1.
//  Throughput: at most one op per WORDS+2 cycles. There is no IDLE bypass, and no grant is issued while in DONE.
//  Boundaries:
//   - Requests raised or dropped outside IDLE are ignored; there is no queueing.
//   - A requester may hold req_valid across ops and is then re-granted only in its round-robin turn.
//   - Overflow wraps: the sum is truncated to W*WORDS bits and the MSW carry is reported in rsp_cout.
//   - Carry propagates correctly through every word boundary, including all-ones words.
//   - rst asserted mid-RUN or mid-DONE aborts the op: no response is produced, and all outputs take reset values immediately.
//   - Operand changes after the handshake do not affect the result, because operands are latched.
// STRUCTURE
//  Shared package mp_add_pkg:
//   - State encoding localparams: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//   - Defaults for W and WORDS.
//  Sub-module add32_cin: 32-bit carry-select adder with a carry-in port (sum, cout, a, b, cin), instantiated once.
//  Remaining logic in this module: round-robin arbiter, FSM, word counter, operand/result registers.
// TESTING
//  1. Reset: rst=1 mid-RUN -> req_ready=0, rsp_valid=0, rsp_sum=0 same cycle; no response after release.
//  2. Single add, req0: A=128'h1, B=128'hFFFF_FFFF (word 0 only).
//     -> rsp_sum=128'h1_0000_0000, rsp_cout=0, rsp_id=0.
//     -> rsp_valid rises exactly 5 cycles after the handshake.
//  3. Full ripple: A=all-ones, B=1, sub=0 -> rsp_sum=0, rsp_cout=1; carry crosses all 4 words.
//  4. Subtract, req1: A=0, B=1, sub=1 -> rsp_sum=all-ones, rsp_cout=0 (borrow), rsp_id=1.
//     A=5, B=3, sub=1 -> rsp_sum=2, rsp_cout=1.
//  5. Arbitration: req_valid=2'b11 held for 4 ops -> grant order 0,1,0,1; rsp_id matches each op.
//  6. Backpressure: rsp_ready=0 for 10 cycles in DONE -> outputs stable, req_ready=0 throughout.
//     rsp_ready=1 -> next grant one cycle later.

Source files
------------

// File: rtl/mp_add_pkg.sv
// Shared definitions for the multi-precision add/subtract scheduler.
package mp_add_pkg;

  localparam int DEF_W     = 32;
  localparam int DEF_WORDS = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/mp_add_sched_add32_cin.sv
// Carry-select adder with carry in: the upper half is computed for both
// possible carries and the lower half's carry out picks the right one.
module add32_cin
  import mp_add_pkg::*;
#(
  parameter int W = DEF_W
) (
  output logic [W-1:0] sum,
  output logic         cout,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin
);

  localparam int LO = W / 2;
  localparam int HI = W - LO;

  logic [LO:0] lo_sum;
  logic [HI:0] hi_sum0;
  logic [HI:0] hi_sum1;

  assign lo_sum  = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]} + {{LO{1'b0}}, cin};
  assign hi_sum0 = {1'b0, a[W-1:LO]} + {1'b0, b[W-1:LO]};
  assign hi_sum1 = {1'b0, a[W-1:LO]} + {1'b0, b[W-1:LO]} + {{HI{1'b0}}, 1'b1};

  assign sum[LO-1:0]        = lo_sum[LO-1:0];
  assign {cout, sum[W-1:LO]} = lo_sum[LO] ? hi_sum1 : hi_sum0;

endmodule

// File: rtl/mp_add_sched.sv
// Round-robin scheduler that streams one WORDS*W-bit add/sub at a time
// through a single shared W-bit adder, least significant word first.
module mp_add_sched
  import mp_add_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int WORDS = DEF_WORDS,
  parameter int NREQ  = 2,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_sub,
  input  logic [NREQ*W*WORDS-1:0] req_a,
  input  logic [NREQ*W*WORDS-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [W*WORDS-1:0]      rsp_sum,
  output logic                    rsp_cout,
  output logic [IDW-1:0]          rsp_id
);

  localparam int OPW = W * WORDS;
  localparam int IXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and ready is only offered in IDLE.

  state_t           state;
  state_t           next_state;
  logic [IDW-1:0]   rr_ptr;
  logic [IXW-1:0]   idx;
  logic             carry;
  logic [OPW-1:0]   op_a;
  logic [OPW-1:0]   op_b;
  logic             op_sub;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   next_ptr;
  logic             accept;
  logic             last_word;

  logic [W-1:0]     add_a;
  logic [W-1:0]     add_b;
  logic [W-1:0]     add_sum;
  logic             add_cout;

  // First requesting index at or after rr_ptr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign next_ptr  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  assign accept    = (state == S_IDLE) && grant_found && !rst;
  assign last_word = (idx == IXW'(WORDS - 1));

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  assign rsp_valid = (state == S_DONE);

  assign add_a = op_a[int'(idx)*W +: W];
  assign add_b = op_sub ? ~op_b[int'(idx)*W +: W] : op_b[int'(idx)*W +: W];

  add32_cin #(.W(W)) u_add (
    .sum  (add_sum),
    .cout (add_cout),
    .a    (add_a),
    .b    (add_b),
    .cin  (carry)
  );

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept) next_state = S_RUN;
      S_RUN:   if (last_word) next_state = S_DONE;
      S_DONE:  if (rsp_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_sub   <= 1'b0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_id   <= '0;
    end else begin
      state <= next_state;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_a   <= req_a[int'(grant_idx)*OPW +: OPW];
            op_b   <= req_b[int'(grant_idx)*OPW +: OPW];
            op_sub <= req_sub[grant_idx];
            carry  <= req_sub[grant_idx];
            rsp_id <= grant_idx;
            rr_ptr <= next_ptr;
            idx    <= '0;
          end
        end
        S_RUN: begin
          rsp_sum[int'(idx)*W +: W] <= add_sum;
          carry <= add_cout;
          if (last_word) rsp_cout <= add_cout;
          else           idx      <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mp_add_sched.sv
// Directed bench for mp_add_sched: arithmetic, latency, arbitration order,
// backpressure and mid-operation reset.
module tb_mp_add_sched;

  localparam int W     = 32;
  localparam int WORDS = 4;
  localparam int NREQ  = 2;
  localparam int OPW   = W * WORDS;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_sub;
  logic [NREQ*OPW-1:0]   req_a;
  logic [NREQ*OPW-1:0]   req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [OPW-1:0]        rsp_sum;
  logic                  rsp_cout;
  logic                  rsp_id;

  int checks = 0;
  int errors = 0;

  mp_add_sched #(.W(W), .WORDS(WORDS), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sub   (req_sub),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int id, input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                        input logic sub, input logic [OPW-1:0] exp_sum,
                        input logic exp_cout, input string name);
    int n;
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_sub[id] = sub;
    req_a[id*OPW +: OPW] = a;
    req_b[id*OPW +: OPW] = b;
    #1;
    n = 0;
    while (req_ready[id] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (req_ready !== (NREQ'(1) << id))
      $display("FAIL %s grant: got %b expected %b", name, req_ready, NREQ'(1) << id);
    if (req_ready !== (NREQ'(1) << id)) errors++;
    tick();
    // scramble operands after the handshake; the result must not change
    req_valid = '0;
    req_a = {8{$urandom()}};
    req_b = {8{$urandom()}};
    req_sub = ~req_sub;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != WORDS + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles expected %0d", name, n, WORDS + 1);
    end
    checks++;
    if (rsp_sum !== exp_sum) begin
      errors++;
      $display("FAIL %s sum: got %h expected %h", name, rsp_sum, exp_sum);
    end
    checks++;
    if (rsp_cout !== exp_cout) begin
      errors++;
      $display("FAIL %s cout: got %b expected %b", name, rsp_cout, exp_cout);
    end
    checks++;
    if (rsp_id !== id[0]) begin
      errors++;
      $display("FAIL %s id: got %0d expected %0d", name, rsp_id, id);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s rsp_valid_drop: got %b expected 0", name, rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    req_sub = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 1'b0 || rsp_sum !== '0 ||
        rsp_cout !== 1'b0 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got ready=%b valid=%b sum=%h cout=%b id=%0d expected all zero",
               req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
    req_valid = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add();
    run_op(0, 128'h1, 128'hFFFF_FFFF, 1'b0, 128'h1_0000_0000, 1'b0, "add_word0");
    run_op(0, 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0,
           128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0, "add_three_words");
    run_op(1, {OPW{1'b1}}, {OPW{1'b1}}, 1'b0,
           128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b1, "add_overflow");
  endtask

  task automatic test_ripple();
    run_op(0, {OPW{1'b1}}, 128'h1, 1'b0, 128'h0, 1'b1, "ripple");
  endtask

  task automatic test_sub();
    run_op(1, 128'h0, 128'h1, 1'b1, {OPW{1'b1}}, 1'b0, "sub_borrow");
    run_op(1, 128'h5, 128'h3, 1'b1, 128'h2, 1'b1, "sub_small");
  endtask

  task automatic test_arbitration();
    int n;
    int exp_id;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    req_valid = 2'b11;
    req_sub = 2'b10;
    req_a = {128'd10, 128'd10};
    req_b = {128'd3, 128'd3};
    #1;
    for (int op = 0; op < 4; op++) begin
      exp_id = op % 2;
      n = 0;
      while (req_ready === 2'b00 && n < 20) begin
        tick();
        n++;
      end
      checks++;
      if (req_ready !== (NREQ'(1) << exp_id)) begin
        errors++;
        $display("FAIL arb_grant%0d: got %b expected %b", op, req_ready, NREQ'(1) << exp_id);
      end
      tick();
      n = 0;
      while (rsp_valid !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      checks++;
      if (rsp_id !== exp_id[0] || rsp_sum !== (exp_id == 1 ? 128'd7 : 128'd13) ||
          rsp_cout !== (exp_id == 1)) begin
        errors++;
        $display("FAIL arb_rsp%0d: got id=%0d sum=%0d cout=%b expected id=%0d sum=%0d cout=%b",
                 op, rsp_id, rsp_sum, rsp_cout, exp_id, (exp_id == 1 ? 7 : 13), exp_id == 1);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    req_valid = 2'b10;
    req_sub = 2'b00;
    req_a[OPW +: OPW] = 128'd100;
    req_b[OPW +: OPW] = 128'd1;
    #1;
    n = 0;
    while (req_ready !== 2'b10 && n < 20) begin
      tick();
      n++;
    end
    tick();
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 128'd101 || rsp_cout !== 1'b0 ||
          rsp_id !== 1'b1 || req_ready !== 2'b00) begin
        errors++;
        $display("FAIL backpressure_hold%0d: got valid=%b sum=%0d cout=%b id=%0d ready=%b expected 1/101/0/1/00",
                 c, rsp_valid, rsp_sum, rsp_cout, rsp_id, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin
      errors++;
      $display("FAIL backpressure_release: got valid=%b ready=%b expected 0/10", rsp_valid, req_ready);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid_run();
    int n;
    int seen;
    req_valid = 2'b01;
    req_sub = 2'b00;
    req_a[0 +: OPW] = 128'd1;
    req_b[0 +: OPW] = 128'd2;
    #1;
    n = 0;
    while (req_ready !== 2'b01 && n < 20) begin
      tick();
      n++;
    end
    tick();
    req_valid = 2'b10;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 1'b0 || rsp_sum !== '0 ||
        rsp_cout !== 1'b0 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: got ready=%b valid=%b sum=%h cout=%b id=%0d expected all zero",
               req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
    tick();
    req_valid = '0;
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_no_response: got %0d cycles with rsp_valid expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ripple();
    test_sub();
    test_arbitration();
    test_backpressure();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
